// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: XLEN x NREG register file with a per-register pending-write (busy) scoreboard.
// Latency: reads and busy status are combinational (optional same-cycle write forwarding); writes/issues commit at CLK rise.
// Backpressure: ready is low for NREG cycles after reset while the array is swept to zero; we/issue_valid are ignored then.
// Ports: CLK, reset (synchronous, active-high)
//        a1/a2 -> do1/do2, busy1/busy2 : two combinational read ports with pending status
//        we/ad/di                      : writeback port, clears the pending bit of ad
//        issue_valid/issue_rd          : marks destination issue_rd pending
//        ready                         : block is in RUN and accepts writes and issues
module regfile_scoreboard #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic [AW-1:0]   a1,
   input  logic [AW-1:0]   a2,
   output logic [XLEN-1:0] do1,
   output logic [XLEN-1:0] do2,
   output logic            busy1,
   output logic            busy2,
   input  logic            we,
   input  logic [AW-1:0]   ad,
   input  logic [XLEN-1:0] di,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            ready
);

   localparam bit          FWD  = (BYPASS != 0);
   localparam bit          FULL = (NREG >= (1 << AW));
   localparam logic [AW-1:0] LAST = AW'(NREG - 1);

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t          state;
   logic [AW-1:0]   clr_ptr;
   logic [NREG-1:0] busy;

   // Storage has no reset so it can map onto a RAM; the CLEAR sweep zeroes it.
   logic [XLEN-1:0] regs [NREG];

   // Address range qualifiers. When NREG fills the whole address space every
   // address is in range and the compare is dropped.
   logic a1_ok, a2_ok, ad_ok, rd_ok;

   if (FULL) begin : g_full
      assign a1_ok = 1'b1;
      assign a2_ok = 1'b1;
      assign ad_ok = 1'b1;
      assign rd_ok = 1'b1;
   end else begin : g_part
      localparam logic [AW:0] NREG_W = (AW+1)'(NREG);
      assign a1_ok = ({1'b0, a1}       < NREG_W);
      assign a2_ok = ({1'b0, a2}       < NREG_W);
      assign ad_ok = ({1'b0, ad}       < NREG_W);
      assign rd_ok = ({1'b0, issue_rd} < NREG_W);
   end

   // Qualified writeback and issue. Reset overrides both, including the
   // forwarding path, so nothing leaks through during the reset cycle.
   logic wr_hit, iss_hit;

   assign wr_hit  = ready && !reset && we          && (ad != '0)       && ad_ok;
   assign iss_hit = ready && !reset && issue_valid && (issue_rd != '0) && rd_ok;

   // Single RAM write port shared by the clear sweep and the writeback.
   logic            ram_we;
   logic [AW-1:0]   ram_wa;
   logic [XLEN-1:0] ram_wd;

   assign ram_we = !reset && ((state == CLEAR) || wr_hit);
   assign ram_wa = (state == CLEAR) ? clr_ptr : ad;
   assign ram_wd = (state == CLEAR) ? '0      : di;

   always_ff @(posedge CLK) begin
      if (ram_we) begin
         regs[ram_wa] <= ram_wd;
      end
   end

   // Control FSM, clear pointer, ready and the busy vector.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state   <= CLEAR;
         clr_ptr <= '0;
         ready   <= 1'b0;
         busy    <= '0;
      end else begin
         case (state)
            CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == LAST) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               // The issue is younger than the retiring write, so its set
               // is placed last and wins on a same-register collision.
               if (wr_hit) begin
                  busy[ad] <= 1'b0;
               end
               if (iss_hit) begin
                  busy[issue_rd] <= 1'b1;
               end
            end
            default: begin
               state <= CLEAR;
               ready <= 1'b0;
            end
         endcase
      end
   end

   // Read ports. Forwarding also hides the busy bit of a register whose
   // pending write is landing this cycle.
   logic fwd1, fwd2;

   assign fwd1 = FWD && wr_hit && (ad == a1);
   assign fwd2 = FWD && wr_hit && (ad == a2);

   assign do1 = (!ready || !a1_ok || (a1 == '0)) ? '0 :
                fwd1                             ? di : regs[a1];
   assign do2 = (!ready || !a2_ok || (a2 == '0)) ? '0 :
                fwd2                             ? di : regs[a2];

   assign busy1 = ready && a1_ok && busy[a1] && !fwd1;
   assign busy2 = ready && a2_ok && busy[a2] && !fwd2;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed bench for regfile_scoreboard (forwarding and non-forwarding builds side by side).
// Latency: expected responses are queued per cycle and checked half a cycle later.
// Backpressure: none; the driver and monitor run in lockstep on a shared cycle counter.
module tb_regfile_scoreboard;

   logic        CLK = 1'b0;
   logic        reset;
   logic [4:0]  a1, a2, ad, issue_rd;
   logic [31:0] di;
   logic        we, issue_valid;

   logic [31:0] do1, do2, do1_nb, do2_nb;
   logic        busy1, busy2, busy1_nb, busy2_nb;
   logic        ready, ready_nb;

   always #5 CLK = ~CLK;

   regfile_scoreboard #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1)) u_fwd (
      .CLK(CLK), .reset(reset),
      .a1(a1), .a2(a2), .do1(do1), .do2(do2), .busy1(busy1), .busy2(busy2),
      .we(we), .ad(ad), .di(di),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .ready(ready)
   );

   regfile_scoreboard #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(0)) u_nb (
      .CLK(CLK), .reset(reset),
      .a1(a1), .a2(a2), .do1(do1_nb), .do2(do2_nb), .busy1(busy1_nb), .busy2(busy2_nb),
      .we(we), .ad(ad), .di(di),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .ready(ready_nb)
   );

   typedef struct {
      int          tag;
      string       name;
      logic        rdy;
      logic [31:0] d1;
      logic        b1;
      logic [31:0] d2;
      logic        b2;
      logic [31:0] d1n;
      logic        b1n;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always @(posedge CLK) cyc = cyc + 1;

   // Monitor: compare every queued expectation that belongs to this cycle.
   always @(negedge CLK) begin
      exp_t e;
      while (q.size() != 0 && q[0].tag <= cyc) begin
         e = q.pop_front();
         n_chk++;
         if (ready === e.rdy && ready_nb === e.rdy &&
             do1 === e.d1 && busy1 === e.b1 && do2 === e.d2 && busy2 === e.b2 &&
             do1_nb === e.d1n && busy1_nb === e.b1n) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got rdy=%b/%b do1=%h b1=%b do2=%h b2=%b nb_do1=%h nb_b1=%b ; want rdy=%b do1=%h b1=%b do2=%h b2=%b nb_do1=%h nb_b1=%b",
                     e.name, ready, ready_nb, do1, busy1, do2, busy2, do1_nb, busy1_nb,
                     e.rdy, e.d1, e.b1, e.d2, e.b2, e.d1n, e.b1n);
         end
      end
   end

   task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic iv, input logic [4:0] ir, input logic [4:0] ra1, input logic [4:0] ra2);
      reset       = r;
      we          = w;
      ad          = wa;
      di          = wd;
      issue_valid = iv;
      issue_rd    = ir;
      a1          = ra1;
      a2          = ra2;
   endtask

   task automatic want(input string nm, input logic rdy,
                       input logic [31:0] d1, input logic b1, input logic [31:0] d2, input logic b2,
                       input logic [31:0] d1n, input logic b1n);
      exp_t e;
      e.tag = cyc; e.name = nm; e.rdy = rdy;
      e.d1 = d1; e.b1 = b1; e.d2 = d2; e.b2 = b2; e.d1n = d1n; e.b1n = b1n;
      q.push_back(e);
   endtask

   task automatic nxt();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      nxt();

      // Sweep after reset: ready low for 32 cycles, writes and issues ignored.
      for (int i = 1; i <= 32; i++) begin
         drive(0, 1, 5'd3, 32'h0000_1234, 1, 5'd4, 5'd3, 5'd4);
         want($sformatf("sweep%0d", i), 0, 0, 0, 0, 0, 0, 0);
         nxt();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      want("ready_rise", 1, 0, 0, 0, 0, 0, 0);
      nxt();

      // Every register reads zero and nothing is pending.
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, 0, 0, 0, 0, 5'(i), 5'(i + 16));
         want($sformatf("zero_rd%0d", i), 1, 0, 0, 0, 0, 0, 0);
         nxt();
      end

      // Write to r5 with same-cycle read on both ports.
      drive(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 5'd5, 5'd5);
      want("wr5_same", 1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 0, 0);
      nxt();
      drive(0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
      want("wr5_next", 1, 32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 0);
      nxt();

      // Writes to r0 are discarded.
      drive(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 5'd0, 5'd5);
      want("wr0_same", 1, 0, 0, 32'hDEAD_BEEF, 0, 0, 0);
      nxt();
      drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
      want("wr0_next", 1, 0, 0, 0, 0, 0, 0);
      nxt();

      // Issue r7, then retire it.
      drive(0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
      want("iss7_same", 1, 0, 0, 0, 0, 0, 0);
      nxt();
      drive(0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
      want("iss7_busy", 1, 0, 1, 0, 1, 0, 1);
      nxt();
      drive(0, 1, 5'd7, 32'h0000_0077, 0, 0, 5'd7, 5'd0);
      want("wb7_same", 1, 32'h0000_0077, 0, 0, 0, 0, 1);
      nxt();
      drive(0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
      want("wb7_after", 1, 32'h0000_0077, 0, 32'h0000_0077, 0, 32'h0000_0077, 0);
      nxt();

      // Issue and write r9 in the same cycle: the set wins, data lands.
      drive(0, 1, 5'd9, 32'h0000_0099, 1, 5'd9, 5'd9, 5'd5);
      want("iss_wb9_same", 1, 32'h0000_0099, 0, 32'hDEAD_BEEF, 0, 0, 0);
      nxt();
      drive(0, 0, 0, 0, 0, 0, 5'd9, 5'd9);
      want("iss_wb9_after", 1, 32'h0000_0099, 1, 32'h0000_0099, 1, 32'h0000_0099, 1);
      nxt();

      // Highest register.
      drive(0, 1, 5'd31, 32'h3131_3131, 0, 0, 5'd31, 5'd0);
      want("wr31_same", 1, 32'h3131_3131, 0, 0, 0, 0, 0);
      nxt();
      drive(0, 0, 0, 0, 0, 0, 5'd31, 5'd9);
      want("wr31_next", 1, 32'h3131_3131, 0, 32'h0000_0099, 1, 32'h3131_3131, 0);
      nxt();

      // Reset in RUN, let the sweep reach clr_ptr = 12, then reset again.
      drive(1, 0, 0, 0, 0, 0, 5'd7, 5'd0);
      nxt();
      for (int i = 1; i <= 12; i++) begin
         drive(0, 1, 5'd20, 32'h0000_00AA, 1, 5'd20, 5'd20, 5'd9);
         want($sformatf("part%0d", i), 0, 0, 0, 0, 0, 0, 0);
         nxt();
      end
      drive(1, 1, 5'd20, 32'h0000_00AA, 1, 5'd20, 5'd20, 5'd9);
      want("rst_mid", 0, 0, 0, 0, 0, 0, 0);
      nxt();
      for (int i = 1; i <= 32; i++) begin
         drive(0, 1, 5'd20, 32'h0000_00AA, 1, 5'd20, 5'd20, 5'd9);
         want($sformatf("resweep%0d", i), 0, 0, 0, 0, 0, 0, 0);
         nxt();
      end
      drive(0, 0, 0, 0, 0, 0, 5'd5, 5'd7);
      want("rerdy_5_7", 1, 0, 0, 0, 0, 0, 0);
      nxt();
      drive(0, 0, 0, 0, 0, 0, 5'd9, 5'd31);
      want("rerdy_9_31", 1, 0, 0, 0, 0, 0, 0);
      nxt();
      drive(0, 0, 0, 0, 0, 0, 5'd20, 5'd3);
      want("rerdy_20_3", 1, 0, 0, 0, 0, 0, 0);
      nxt();

      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5 && q.size() != 0; i++) begin
         @(negedge CLK);
      end
      if (q.size() != 0) begin
         n_chk++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
